// File: rtl/fft8_pkg.sv
// Shared types and constants for the 8-point FFT datapath blocks (S2P, FFT core, P2S, sequencer).
package fft8_pkg;

   localparam int N_PTS = 8;
   localparam int IDX_W = 3;

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      COMPUTE = 2'd1,
      LOAD    = 2'd2,
      DRAIN   = 2'd3
   } fft8_state_t;

   typedef logic [15:0] fft8_word_t;

   function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] idx);
      return idx + {{(IDX_W-1){1'b0}}, 1'b1};
   endfunction

endpackage

// File: rtl/fft8_frame_ctrl_if.sv
// Handshake and strobe bundle between the frame sequencer and the FFT datapath / stream neighbours.
interface fft8_frame_ctrl_if;
   import fft8_pkg::*;

   logic             in_valid;
   logic             in_ready;
   logic             s2p_en;
   logic             fft_start;
   logic             fft_done;
   logic             p2s_ld;
   logic             p2s_en;
   logic             out_valid;
   logic             out_ready;
   logic [IDX_W-1:0] out_idx;
   logic             out_last;

   modport master (
      input  in_valid, fft_done, out_ready,
      output in_ready, s2p_en, fft_start, p2s_ld, p2s_en, out_valid, out_idx, out_last
   );

   modport slave (
      output in_valid, fft_done, out_ready,
      input  in_ready, s2p_en, fft_start, p2s_ld, p2s_en, out_valid, out_idx, out_last
   );

endinterface

// File: rtl/fft8_wdog.sv
// Compute-phase watchdog: cleared outside COMPUTE, counts enabled cycles, flags the last allowed one.
module fft8_wdog #(
   parameter int TIMEOUT = 64
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tc
);
   localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   logic [CW-1:0] cnt_r;

   // tc fires on the cycle whose increment would bring the count to TIMEOUT
   assign tc = en && (cnt_r == CW'(TIMEOUT - 1));

   // watchdog count register
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r <= {CW{1'b0}};
      end else if (clr) begin
         cnt_r <= {CW{1'b0}};
      end else if (en && !tc) begin
         cnt_r <= cnt_r + CW'(1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

endmodule

// File: rtl/fft8_frame_ctrl.sv
// Frame sequencer for the 8-point FFT: counts S2P samples, starts the core under a watchdog,
// then loads and drains the P2S register one word per accepted beat.
module fft8_frame_ctrl #(
   parameter int N_PTS   = 8,
   parameter int TIMEOUT = 64,
   parameter int FCNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   fft8_frame_ctrl_if.master bus,
   output logic [FCNT_W-1:0] frame_cnt,
   output logic              timeout_err,
   output logic              busy
);
   import fft8_pkg::*;

   fft8_state_t      state_r;
   fft8_state_t      state_s;
   logic [IDX_W-1:0] smp_cnt_r;
   logic [IDX_W-1:0] out_idx_r;
   logic [FCNT_W-1:0] frame_cnt_r;
   logic             fft_start_r;
   logic             p2s_ld_r;
   logic             out_valid_r;
   logic             out_last_r;
   logic             timeout_err_r;
   logic             busy_r;

   logic             in_ready_s;
   logic             s2p_en_s;
   logic             p2s_en_s;
   logic             last_in_s;
   logic             last_out_s;
   logic             done_ok_s;
   logic             wd_en_s;
   logic             wd_clr_s;
   logic             wd_tc_s;

   logic             fft_start_s;
   logic             p2s_ld_s;
   logic             out_valid_s;
   logic             out_last_s;
   logic             busy_s;
   logic             timeout_err_s;
   logic [IDX_W-1:0] smp_next_s;
   logic [IDX_W-1:0] idx_next_s;
   logic [FCNT_W-1:0] frame_next_s;

   // in_ready is held low while rst is asserted so no sample is taken during reset
   assign in_ready_s = (state_r == COLLECT) && !rst;
   assign s2p_en_s   = bus.in_valid && in_ready_s;
   assign p2s_en_s   = out_valid_r && bus.out_ready;
   assign last_in_s  = s2p_en_s && (smp_cnt_r == IDX_W'(N_PTS - 1));
   assign last_out_s = p2s_en_s && (out_idx_r == IDX_W'(N_PTS - 1));
   // the start cycle itself never counts as done
   assign done_ok_s  = (state_r == COMPUTE) && !fft_start_r && bus.fft_done;
   assign wd_en_s    = (state_r == COMPUTE);
   assign wd_clr_s   = !wd_en_s;

   fft8_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
      .clk (clk),
      .rst (rst),
      .clr (wd_clr_s),
      .en  (wd_en_s),
      .tc  (wd_tc_s)
   );

   // next-state decode; done beats the watchdog when both fire together
   always_comb begin
      state_s = state_r;
      case (state_r)
         COLLECT: begin
            if (last_in_s) state_s = COMPUTE;
            else           state_s = COLLECT;
         end
         COMPUTE: begin
            if (done_ok_s)    state_s = LOAD;
            else if (wd_tc_s) state_s = COLLECT;
            else              state_s = COMPUTE;
         end
         LOAD:    state_s = DRAIN;
         DRAIN: begin
            if (last_out_s) state_s = COLLECT;
            else            state_s = DRAIN;
         end
         default: state_s = COLLECT;
      endcase
   end

   // next values of the registered outputs and counters
   always_comb begin
      fft_start_s   = (state_r == COLLECT) && (state_s == COMPUTE);
      p2s_ld_s      = (state_s == LOAD);
      out_valid_s   = (state_s == DRAIN);
      busy_s        = (state_s != COLLECT);
      timeout_err_s = timeout_err_r || ((state_r == COMPUTE) && !done_ok_s && wd_tc_s);

      if (s2p_en_s) smp_next_s = idx_inc(smp_cnt_r);
      else          smp_next_s = smp_cnt_r;

      if (state_s == LOAD)  idx_next_s = {IDX_W{1'b0}};
      else if (p2s_en_s)    idx_next_s = idx_inc(out_idx_r);
      else                  idx_next_s = out_idx_r;

      out_last_s = out_valid_s && (idx_next_s == IDX_W'(N_PTS - 1));

      if (last_out_s) frame_next_s = frame_cnt_r + FCNT_W'(1);
      else            frame_next_s = frame_cnt_r;
   end

   // state and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r       <= COLLECT;
         smp_cnt_r     <= {IDX_W{1'b0}};
         out_idx_r     <= {IDX_W{1'b0}};
         frame_cnt_r   <= {FCNT_W{1'b0}};
         fft_start_r   <= 1'b0;
         p2s_ld_r      <= 1'b0;
         out_valid_r   <= 1'b0;
         out_last_r    <= 1'b0;
         timeout_err_r <= 1'b0;
         busy_r        <= 1'b0;
      end else begin
         state_r       <= state_s;
         smp_cnt_r     <= smp_next_s;
         out_idx_r     <= idx_next_s;
         frame_cnt_r   <= frame_next_s;
         fft_start_r   <= fft_start_s;
         p2s_ld_r      <= p2s_ld_s;
         out_valid_r   <= out_valid_s;
         out_last_r    <= out_last_s;
         timeout_err_r <= timeout_err_s;
         busy_r        <= busy_s;
      end
   end

   assign bus.in_ready  = in_ready_s;
   assign bus.s2p_en    = s2p_en_s;
   assign bus.p2s_en    = p2s_en_s;
   assign bus.fft_start = fft_start_r;
   assign bus.p2s_ld    = p2s_ld_r;
   assign bus.out_valid = out_valid_r;
   assign bus.out_idx   = out_idx_r;
   assign bus.out_last  = out_last_r;
   assign frame_cnt     = frame_cnt_r;
   assign timeout_err   = timeout_err_r;
   assign busy          = busy_r;

endmodule

// File: tb/tb_fft8_frame_ctrl.sv
// Bench for fft8_frame_ctrl: frame-level reference model checked every cycle, scenario table,
// reset-in-drain sequence and a randomized soak, with a small S2P/P2S data model for word order.
module tb_fft8_frame_ctrl;
   import fft8_pkg::*;

   localparam int TIMEOUT = 16;
   localparam int FCNT_W  = 2;

   typedef struct {
      int gap;        // 0 continuous, 1 alternating, 2 random in_valid
      int lat;        // core done delay after start, -1 never
      int stall_at;   // out word index to stall on, 99 none, -2 random out_ready
      int stall_len;
      int exp_in;
      int exp_start;
      int exp_ld;
      int exp_out;
      int exp_fc;
      int exp_terr;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   logic [FCNT_W-1:0] frame_cnt;
   logic timeout_err;
   logic busy;

   fft8_frame_ctrl_if bus();

   fft8_frame_ctrl #(.N_PTS(8), .TIMEOUT(TIMEOUT), .FCNT_W(FCNT_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .frame_cnt   (frame_cnt),
      .timeout_err (timeout_err),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   int tests_run = 0;
   int failed    = 0;
   int cyc       = 0;
   int cur_vec   = -1;

   // frame-level reference model
   bit m_collect;
   int m_taken;
   int m_core;     // cycles since core start, -1 when core idle
   bit m_load;
   int m_sent;     // words delivered so far, -1 when not delivering
   int m_frames;
   bit m_terr;

   int n_in, n_start, n_ld, n_out, stalled;

   fft8_word_t in_data;
   fft8_word_t in_words [8] = '{16'h1234, 16'h5678, 16'hABCD, 16'hCDEF,
                                16'h0123, 16'h7894, 16'h1987, 16'h4561};
   fft8_word_t s2p_q [$];
   fft8_word_t p2s_q [$];

   vec_t vecs [7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s (cycle %0d, vec %0d): got %0h expected %0h", name, cyc, cur_vec, act, exp);
      end
   endtask

   task automatic model_reset();
      m_collect = 1'b1;
      m_taken   = 0;
      m_core    = -1;
      m_load    = 1'b0;
      m_sent    = -1;
      m_frames  = 0;
      m_terr    = 1'b0;
   endtask

   task automatic model_advance();
      if (rst) begin
         model_reset();
      end else if (m_collect) begin
         if (bus.in_valid) begin
            m_taken++;
            if (m_taken == 8) begin
               m_taken   = 0;
               m_collect = 1'b0;
               m_core    = 0;
            end
         end
      end else if (m_core >= 0) begin
         if (m_core >= 1 && bus.fft_done) begin
            m_core = -1;
            m_load = 1'b1;
         end else if (m_core + 1 >= TIMEOUT) begin
            m_core    = -1;
            m_terr    = 1'b1;
            m_collect = 1'b1;
         end else begin
            m_core++;
         end
      end else if (m_load) begin
         m_load = 1'b0;
         m_sent = 0;
      end else if (m_sent >= 0 && bus.out_ready) begin
         if (m_sent == 7) begin
            m_sent    = -1;
            m_frames++;
            m_collect = 1'b1;
         end else begin
            m_sent++;
         end
      end
   endtask

   // one clock: compare at negedge, advance model, return just after the next rising edge
   task automatic step();
      logic e_ir, e_ov;
      int   e_idx;
      @(negedge clk);
      e_ir  = m_collect && !rst;
      e_ov  = (m_sent >= 0);
      e_idx = e_ov ? m_sent : 0;
      chk("in_ready",    bus.in_ready,  e_ir);
      chk("s2p_en",      bus.s2p_en,    bus.in_valid && e_ir);
      chk("fft_start",   bus.fft_start, m_core == 0);
      chk("p2s_ld",      bus.p2s_ld,    m_load);
      chk("out_valid",   bus.out_valid, e_ov);
      chk("out_idx",     bus.out_idx,   e_idx);
      chk("out_last",    bus.out_last,  e_ov && e_idx == 7);
      chk("p2s_en",      bus.p2s_en,    e_ov && bus.out_ready);
      chk("frame_cnt",   frame_cnt,     m_frames % (1 << FCNT_W));
      chk("timeout_err", timeout_err,   m_terr);
      chk("busy",        busy,          !m_collect);
      if (bus.s2p_en)    n_in++;
      if (bus.fft_start) n_start++;
      if (bus.p2s_ld)    n_ld++;
      if (bus.p2s_en) begin
         n_out++;
         chk("p2s_fill", p2s_q.size() > 0, 1);
         if (p2s_q.size() > 0) begin
            chk("p2s_word", p2s_q[0], in_words[e_idx]);
            void'(p2s_q.pop_front());
         end
      end
      if (bus.s2p_en) begin
         s2p_q.push_back(in_data);
         if (s2p_q.size() > 8) void'(s2p_q.pop_front());
      end
      if (bus.p2s_ld) p2s_q = s2p_q;
      if (rst) begin
         s2p_q.delete();
         p2s_q.delete();
      end
      model_advance();
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input vec_t v);
      case (v.gap)
         0:       bus.in_valid = 1'b1;
         1:       bus.in_valid = m_collect ? (cyc % 2 == 0) : 1'b1;
         default: bus.in_valid = 1'($urandom_range(0, 1));
      endcase
      in_data      = in_words[m_taken];
      bus.fft_done = (m_core >= 0) && (m_core == v.lat);
      if (v.stall_at == -2) begin
         bus.out_ready = ($urandom_range(0, 2) != 0);
      end else if (m_sent == v.stall_at && stalled < v.stall_len) begin
         bus.out_ready = 1'b0;
         stalled++;
      end else begin
         bus.out_ready = 1'b1;
      end
   endtask

   initial begin
      #20_000_000;
      $display("FAIL global_time_limit: simulation did not finish");
      $fatal(1, "time limit");
   end

   initial begin
      int  k;
      bit  started;
      vec_t hv;

      //            gap lat stall len  in st ld out fc terr
      vecs[0] = '{0,   5, 99, 0,  8, 1, 1, 8, 1, 0};  // nominal
      vecs[1] = '{1,   5, 99, 0,  8, 1, 1, 8, 2, 0};  // gapped input, valid held while busy
      vecs[2] = '{0,   3,  3, 4,  8, 1, 1, 8, 3, 0};  // backpressure at word 3
      vecs[3] = '{0,  -1, 99, 0,  8, 1, 0, 0, 3, 1};  // core never done
      vecs[4] = '{1,   2, 99, 0,  8, 1, 1, 8, 0, 1};  // recovers after timeout, count wraps
      vecs[5] = '{2,   1, -2, 0,  8, 1, 1, 8, 1, 1};  // fastest core, random flow
      vecs[6] = '{0,   0, 99, 0,  8, 1, 0, 0, 1, 1};  // done only in start cycle

      rst = 1'b1;
      bus.in_valid = 1'b0;
      bus.fft_done = 1'b0;
      bus.out_ready = 1'b0;
      in_data = 16'h0000;
      repeat (3) @(posedge clk);
      #1;
      model_reset();
      step();
      rst = 1'b0;
      step();

      for (int v = 0; v < 7; v++) begin
         cur_vec = v;
         n_in = 0; n_start = 0; n_ld = 0; n_out = 0; stalled = 0;
         k = 0;
         started = 1'b0;
         while (k < 200) begin
            drive(vecs[v]);
            step();
            k++;
            if (!m_collect) started = 1'b1;
            else if (started) break;
         end
         bus.in_valid = 1'b0;
         chk("frame_bound", k < 200, 1);
         chk("n_s2p_en",    n_in,    vecs[v].exp_in);
         chk("n_fft_start", n_start, vecs[v].exp_start);
         chk("n_p2s_ld",    n_ld,    vecs[v].exp_ld);
         chk("n_p2s_en",    n_out,   vecs[v].exp_out);
         chk("vec_frame_cnt", frame_cnt,  vecs[v].exp_fc);
         chk("vec_timeout_err", timeout_err, vecs[v].exp_terr);
         chk("vec_busy", busy, 0);
      end

      // reset while delivering word 5
      cur_vec = 7;
      hv = '{0, 4, 99, 0, 0, 0, 0, 0, 0, 0};
      k = 0;
      while (m_sent != 5 && k < 100) begin
         drive(hv);
         step();
         k++;
      end
      chk("drain5_bound", k < 100, 1);
      rst = 1'b1;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      step();
      rst = 1'b0;
      chk("rst_out_valid",   bus.out_valid,   0);
      chk("rst_out_idx",     bus.out_idx,     0);
      chk("rst_out_last",    bus.out_last,    0);
      chk("rst_busy",        busy,            0);
      chk("rst_frame_cnt",   frame_cnt,       0);
      chk("rst_timeout_err", timeout_err,     0);
      n_start = 0; n_ld = 0;
      for (int i = 0; i < 6; i++) begin
         bus.fft_done = 1'b1;
         step();
      end
      bus.fft_done = 1'b0;
      chk("stray_done_start", n_start, 0);
      chk("stray_done_ld",    n_ld,    0);
      chk("stray_done_busy",  busy,    0);

      // randomized soak against the model
      cur_vec = 8;
      for (int i = 0; i < 600; i++) begin
         rst           = ($urandom_range(0, 249) == 0);
         bus.in_valid  = 1'($urandom_range(0, 1));
         bus.out_ready = ($urandom_range(0, 3) != 0);
         bus.fft_done  = ($urandom_range(0, 5) == 0);
         in_data       = in_words[m_taken];
         step();
      end
      rst = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests_run, failed);
      $finish;
   end

endmodule
